// File: rtl/pattern_seq_ctrl.sv
// pattern_seq_ctrl: word-level sequencer for a serial pattern detector.
// Takes a parallel word over valid/ready and releases the detector from reset.
// It shifts the word in MSB-first, counts det_y match pulses and records the
// first match position. The result is then offered over a second valid/ready
// handshake.
module pattern_seq_ctrl #(
  parameter int W  = 16,
  parameter int CW = $clog2(W + 1),
  parameter int PW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          abort,
  output logic          det_rst_n,
  output logic          det_x,
  input  logic          det_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] match_cnt,
  output logic [PW-1:0] first_pos,
  output logic          match_any
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Index of the last bit of a word; reaching it ends the SHIFT phase.
  localparam logic [PW-1:0] IDX_LAST = PW'(W - 1);

  state_t          state_q,     state_d;
  logic [W-1:0]    shreg_q,     shreg_d;
  logic [PW-1:0]   idx_q,       idx_d;
  logic [CW-1:0]   match_cnt_q, match_cnt_d;
  logic [PW-1:0]   first_pos_q, first_pos_d;
  logic            match_any_q, match_any_d;
  logic            det_rst_n_q, det_rst_n_d;

  // State and datapath registers; rst overrides everything, including mid-word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      match_cnt_q <= '0;
      first_pos_q <= '0;
      match_any_q <= 1'b0;
      det_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      match_cnt_q <= match_cnt_d;
      first_pos_q <= first_pos_d;
      match_any_q <= match_any_d;
      det_rst_n_q <= det_rst_n_d;
    end
  end

  // Next-state and datapath update: load on accept, shift/count in SHIFT,
  // hold in REPORT, abandon on abort.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    match_cnt_d = match_cnt_q;
    first_pos_d = first_pos_q;
    match_any_d = match_any_q;
    det_rst_n_d = det_rst_n_q;

    case (state_q)
      ST_IDLE: begin
        // The detector stays in reset until a word is accepted. It still
        // sees reset on the accept edge, so it starts clean on bit 0.
        det_rst_n_d = 1'b0;
        if (in_valid) begin
          state_d     = ST_SHIFT;
          shreg_d     = in_data;
          idx_d       = '0;
          match_cnt_d = '0;
          first_pos_d = '0;
          match_any_d = 1'b0;
          det_rst_n_d = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          // Drop the word. Clearing shreg keeps det_x quiet in IDLE.
          state_d     = ST_IDLE;
          shreg_d     = '0;
          idx_d       = '0;
          det_rst_n_d = 1'b0;
        end else begin
          shreg_d = {shreg_q[W-2:0], 1'b0};
          idx_d   = idx_q + PW'(1);
          // det_y is Mealy on the bit now on det_x, whose index is idx_q.
          if (det_y) begin
            match_cnt_d = match_cnt_q + CW'(1);
            if (!match_any_q) begin
              first_pos_d = idx_q;
              match_any_d = 1'b1;
            end
          end
          if (idx_q == IDX_LAST) begin
            // Last bit sampled: park the detector and publish the result.
            state_d     = ST_REPORT;
            idx_d       = '0;
            det_rst_n_d = 1'b0;
          end
        end
      end

      ST_REPORT: begin
        // abort together with out_ready is treated as a consumed result.
        det_rst_n_d = 1'b0;
        if (abort || out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        shreg_d     = '0;
        idx_d       = '0;
        det_rst_n_d = 1'b0;
      end
    endcase
  end

  // Handshake flags are pure state decodes. det_x is gated so the detector
  // only ever sees word bits while SHIFT is active.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_REPORT);
    det_x     = (state_q == ST_SHIFT) && shreg_q[W-1];
    det_rst_n = det_rst_n_q;
    match_cnt = match_cnt_q;
    first_pos = first_pos_q;
    match_any = match_any_q;
  end

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Directed bench for pattern_seq_ctrl (W=16).
// The a-x-x-a detector is modelled here: it matches when bit k equals bit k-3.
module tb_pattern_seq_ctrl;

  localparam int W  = 16;
  localparam int CW = 5;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          abort;
  logic          det_rst_n;
  logic          det_x;
  logic          det_y;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] match_cnt;
  logic [PW-1:0] first_pos;
  logic          match_any;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pattern_seq_ctrl #(.W(W), .CW(CW), .PW(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .abort     (abort),
    .det_rst_n (det_rst_n),
    .det_x     (det_x),
    .det_y     (det_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .match_cnt (match_cnt),
    .first_pos (first_pos),
    .match_any (match_any)
  );

  // a-x-x-a detector: 3-bit history plus a count of bits seen since reset.
  logic [2:0] hist;
  int         seen;
  always @(posedge clk) begin
    if (!det_rst_n) begin
      hist <= 3'b000;
      seen <= 0;
    end else begin
      hist <= {hist[1:0], det_x};
      if (seen < 3) seen <= seen + 1;
    end
  end
  assign det_y = det_rst_n && (seen >= 3) && (det_x == hist[2]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at a negedge: present a word and return at the negedge after accept.
  task automatic do_accept(input logic [W-1:0] d, input string tag);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept_wait"}, 32'(n < 50), 32'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Follow the SHIFT phase, capture det_x bits and check the result.
  task automatic finish_word(input string tag, input logic [W-1:0] d,
                             input int cnt, input int fp, input logic any);
    int cyc;
    logic [W-1:0] cap;
    logic busy_ok;
    cyc = 0;
    cap = '0;
    busy_ok = 1'b1;
    while (!out_valid && cyc < 40) begin
      if (cyc < W) cap[W-1-cyc] = det_x;
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"},  32'(cyc), 32'(W));
    check({tag, "_det_x"},    32'(cap), 32'(d));
    check({tag, "_busy"},     32'(busy_ok), 32'(1));
    check({tag, "_cnt"},      32'(match_cnt), 32'(cnt));
    check({tag, "_first"},    32'(first_pos), 32'(fp));
    check({tag, "_any"},      32'(match_any), 32'(any));
  endtask

  // Consume the result (out_ready assumed high) and confirm the return to IDLE.
  task automatic consume(input string tag);
    @(negedge clk);
    check({tag, "_idle"}, 32'({in_ready, out_valid, det_rst_n}), 32'(3'b100));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hold_ok;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    abort     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'(1));
    check("rst_det_rst_n", 32'(det_rst_n), 32'(0));
    check("rst_det_x",     32'(det_x),     32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_cnt",       32'(match_cnt), 32'(0));
    check("rst_any",       32'(match_any), 32'(0));
    check("rst_first",     32'(first_pos), 32'(0));
    rst = 1'b0;

    // Single words with out_ready high
    do_accept(16'hFFFF, "ffff");
    check("ffff_det_rst_n_up", 32'(det_rst_n), 32'(1));
    finish_word("ffff", 16'hFFFF, 13, 3, 1'b1);
    consume("ffff");

    do_accept(16'hAAAA, "aaaa");
    finish_word("aaaa", 16'hAAAA, 0, 0, 1'b0);
    consume("aaaa");

    do_accept(16'h9009, "9009");
    finish_word("9009", 16'h9009, 11, 3, 1'b1);
    consume("9009");

    // Back-to-back words with the consumer stalled for 5 REPORT cycles
    out_ready = 1'b0;
    do_accept(16'h0000, "b2b0");
    finish_word("b2b0", 16'h0000, 13, 3, 1'b1);
    in_data  = 16'hAAAA;
    in_valid = 1'b1;
    hold_ok  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if ({out_valid, in_ready, det_rst_n, match_cnt, first_pos, match_any} !==
          {1'b1, 1'b0, 1'b0, 5'd13, 4'd3, 1'b1}) hold_ok = 1'b0;
    end
    check("b2b0_hold", 32'(hold_ok), 32'(1));
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b_gap", 32'({in_ready, out_valid, det_rst_n}), 32'(3'b100));
    do_accept(16'hAAAA, "b2b1");
    finish_word("b2b1", 16'hAAAA, 0, 0, 1'b0);
    consume("b2b1");

    // Abort during bit 7
    do_accept(16'hFFFF, "abort");
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 32'({in_ready, out_valid, det_rst_n, det_x}), 32'(4'b1000));
    hold_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) hold_ok = 1'b0;
    end
    check("abort_no_result", 32'(hold_ok), 32'(1));

    // Reset mid-SHIFT
    do_accept(16'hFFFF, "midrst");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs",
          32'({in_ready, det_rst_n, det_x, out_valid, match_cnt, first_pos, match_any}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0}));
    rst = 1'b0;
    @(negedge clk);

    // Normal operation resumes
    do_accept(16'hFFFF, "after");
    finish_word("after", 16'hFFFF, 13, 3, 1'b1);
    consume("after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
